led_scroll_ctrl: RTL



---
 rtl/led_scroll_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/led_scroll_ctrl.sv
// Scroll sequencer: shows a 4-character window of a message and advances it at a programmable rate.
// Optional one-shot mode (stop after a single pass) is enabled by defining LED_SCROLL_ONESHOT_EN.
module led_scroll_ctrl #(
    parameter int          MSG_LEN     = 16,
    parameter int          SHIFT_TICKS = 50_000_000,
    parameter logic [3:0]  BLANK       = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       busy,
    output logic       wrap
);

    localparam int             CW     = $clog2(SHIFT_TICKS);
    localparam logic [CW-1:0]  RELOAD = CW'(SHIFT_TICKS - 1);
    localparam logic [3:0]     LAST   = 4'(MSG_LEN - 1);
    localparam logic [4:0]     LEN5   = 5'(MSG_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [3:0]      ptr;
    logic [CW-1:0]   cnt;
    logic            step;
    logic            wrap_step;

    // Sixteen slots keep the 4-bit index exact; only the first MSG_LEN are ever written or read.
    logic [3:0]      mem [16];

    function automatic logic [3:0] win_idx(input logic [3:0] base, input logic [1:0] off);
        logic [4:0] sum;
        sum = {1'b0, base} + {3'b000, off};
        if (sum >= LEN5) begin
            sum = sum - LEN5;
        end
        return sum[3:0];
    endfunction

    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en && ({1'b0, wr_addr} < LEN5)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        next_state = state;
        step       = 1'b0;
        wrap_step  = 1'b0;
        if (state == RUN && !stop && cnt == '0) begin
            step      = 1'b1;
            wrap_step = (ptr == LAST);
        end
        case (state)
            IDLE: begin
                if (!stop && start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    next_state = IDLE;
`ifdef LED_SCROLL_ONESHOT_EN
                end else if (wrap_step) begin
                    next_state = IDLE;
`endif
                end else if (pause) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (!pause) begin
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The counter only moves on RUN cycles, so a pause entered mid-step keeps the step length intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            if (state == IDLE && next_state == RUN) begin
                ptr <= '0;
                cnt <= RELOAD;
            end else if (state == RUN && !stop) begin
                if (step) begin
                    cnt <= RELOAD;
                    ptr <= (ptr == LAST) ? 4'd0 : ptr + 4'd1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit3 <= BLANK;
            digit2 <= BLANK;
            digit1 <= BLANK;
            digit0 <= BLANK;
        end else if (state == IDLE) begin
            digit3 <= BLANK;
            digit2 <= BLANK;
            digit1 <= BLANK;
            digit0 <= BLANK;
        end else begin
            digit3 <= mem[ptr];
            digit2 <= mem[win_idx(ptr, 2'd1)];
            digit1 <= mem[win_idx(ptr, 2'd2)];
            digit0 <= mem[win_idx(ptr, 2'd3)];
        end
    end

`ifdef LED_SCROLL_ONESHOT_EN
    // In one-shot mode the pulse coincides with busy falling, ahead of the blanked digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_step;
        end
    end
`else
    logic wrap_pend;

    // Delayed one extra cycle so the pulse lines up with the digits showing the new window 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_pend <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            wrap_pend <= wrap_step;
            wrap      <= wrap_pend;
        end
    end
`endif

endmodule
